// File: rtl/ddr_lane_serializer_pkg.sv
// Shared definitions for the DDR lane serializer.
// Holds the shifter state encoding and helpers that turn the word width and
// FIFO depth into the beat count, beat-counter width and FIFO count width.
package ddr_lane_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } shift_state_e;

  // Two bits per lane leave the cell each clock cycle.
  function automatic int beats_of(input int word_bits);
    return word_bits / 2;
  endfunction

  // A single-beat word still needs a 1-bit counter so the port is never zero wide.
  function automatic int beat_width(input int word_bits);
    return (word_bits / 2 > 1) ? $clog2(word_bits / 2) : 1;
  endfunction

  // One extra bit so the count can represent a completely full FIFO.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ddr_out_cell.sv
// One-bit DDR output cell.
// Registers a {rise, fall} pair on the rising edge and drives rise while the
// clock is high and fall while it is low. Both registers reset
// asynchronously to IDLE_BIT, so the pin parks on the idle level the moment
// reset is asserted.
// Ports:
//   clock   - serializer clock
//   aresetn - asynchronous active-low reset
//   rise_d  - bit sent in the high half of the next cycle
//   fall_d  - bit sent in the low half of the next cycle
//   q       - DDR output pin
module ddr_out_cell #(
  parameter bit IDLE_BIT = 1'b0
) (
  input  logic clock,
  input  logic aresetn,
  input  logic rise_d,
  input  logic fall_d,
  output logic q
);

`ifdef DDR_OUT_CELL_XILINX_ODDR
  // Vendor primitive: same-edge mode captures both bits on the rising edge.
  ODDR #(
    .DDR_CLK_EDGE("SAME_EDGE"),
    .INIT        (IDLE_BIT),
    .SRTYPE      ("ASYNC")
  ) u_oddr (
    .Q (q),
    .C (clock),
    .CE(1'b1),
    .D1(rise_d),
    .D2(fall_d),
    .R (!aresetn && (IDLE_BIT == 1'b0)),
    .S (!aresetn && (IDLE_BIT == 1'b1))
  );
`else
  logic rise_q;
  logic fall_q;

  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      rise_q <= IDLE_BIT;
      fall_q <= IDLE_BIT;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  // The clock itself selects the half; this is the one non-posedge path.
  assign q = clock ? rise_q : fall_q;
`endif

endmodule

// File: rtl/ddr_lane_serializer.sv
// DDR lane serializer.
// Words enter through a DEPTH-entry FIFO and are shifted out two bits per
// lane per clock cycle through one DDR output cell per lane. Consecutive
// words are sent without gaps when the FIFO keeps up; q_frame marks every
// cycle whose q bits belong to a word, and underrun latches when a word ends
// with the FIFO empty while a new word is only just being offered.
// Ports:
//   clock, aresetn   - clock and asynchronous active-low reset
//   s_valid/s_ready  - input handshake, s_data holds LANES lane words
//   q                - DDR lane outputs
//   q_frame          - SDR flag aligned with q
//   underrun         - sticky underrun flag, cleared by clr_underrun
module ddr_lane_serializer
  import ddr_lane_serializer_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int WORD_BITS = 8,
  parameter int DEPTH     = 4,
  parameter int MSB_FIRST = 1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic                       clock,
  input  logic                       aresetn,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [LANES*WORD_BITS-1:0] s_data,
  output logic [LANES-1:0]           q,
  output logic                       q_frame,
  output logic                       underrun,
  input  logic                       clr_underrun
);

  localparam int BEATS = beats_of(WORD_BITS);
  localparam int BW    = beat_width(WORD_BITS);
  localparam int CW    = count_width(DEPTH);
  localparam int PW    = $clog2(DEPTH);
  localparam int IW    = $clog2(WORD_BITS);
  localparam int DW    = LANES * WORD_BITS;

  logic [DW-1:0]   fifo_mem [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  shift_state_e    state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [DW-1:0]   shreg_q, shreg_d;
  logic            underrun_q, underrun_d;
  logic            rdy_en_q, rdy_en_d;
  logic            frame_q, frame_d;
  logic [LANES-1:0] rise_d, fall_d;
  logic [IW-1:0]   pair_idx, lo_idx, hi_idx, rise_idx, fall_idx;

  logic push, pop, fifo_nempty, last_beat, underrun_set;

  // rdy_en keeps s_ready low until the first edge that sees reset released.
  assign s_ready     = rdy_en_q && (count_q < CW'(DEPTH));
  assign push        = s_valid && s_ready;
  assign fifo_nempty = (count_q != '0);
  assign last_beat   = (state_q == ST_SHIFT) && (beat_q == BW'(BEATS - 1));
  assign pop         = fifo_nempty && ((state_q == ST_IDLE) || last_beat);
  assign underrun_set = last_beat && !fifo_nempty && s_valid;

  // FIFO and control bookkeeping
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    shreg_d  = pop ? fifo_mem[rd_ptr_q] : shreg_q;
    rdy_en_d = 1'b1;
    // A new underrun beats a simultaneous clear.
    if (underrun_set)      underrun_d = 1'b1;
    else if (clr_underrun) underrun_d = 1'b0;
    else                   underrun_d = underrun_q;
  end

  // State register
  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      underrun_q <= 1'b0;
      rdy_en_q   <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      underrun_q <= underrun_d;
      rdy_en_q   <= rdy_en_d;
      frame_q    <= frame_d;
    end
  end

  // Word storage carries no reset; the control path decides what is valid.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr_q] <= s_data;
    shreg_q <= shreg_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (fifo_nempty) begin
          state_d = ST_SHIFT;
          beat_d  = '0;
        end
      end
      ST_SHIFT: begin
        if (last_beat) begin
          beat_d = '0;
          if (!fifo_nempty) state_d = ST_IDLE;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // Output logic: choose the bit pair for the current beat.
  always_comb begin
    pair_idx = (MSB_FIRST != 0) ? IW'(BEATS - 1) - IW'(beat_q) : IW'(beat_q);
    lo_idx   = pair_idx << 1;
    hi_idx   = lo_idx | IW'(1);
    rise_idx = (MSB_FIRST != 0) ? hi_idx : lo_idx;
    fall_idx = (MSB_FIRST != 0) ? lo_idx : hi_idx;
    frame_d  = (state_q == ST_SHIFT);
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [WORD_BITS-1:0] lane_word;
    assign lane_word = shreg_q[k*WORD_BITS +: WORD_BITS];
    assign rise_d[k] = frame_d ? lane_word[rise_idx] : IDLE_BIT;
    assign fall_d[k] = frame_d ? lane_word[fall_idx] : IDLE_BIT;

    ddr_out_cell #(.IDLE_BIT(IDLE_BIT)) u_cell (
      .clock  (clock),
      .aresetn(aresetn),
      .rise_d (rise_d[k]),
      .fall_d (fall_d[k]),
      .q      (q[k])
    );
  end

  assign q_frame  = frame_q;
  assign underrun = underrun_q;

endmodule
